// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 definitions: special values, stream opcodes, header layout
// and the operand sequencer FSM states.
package dlfloat_pkg;

    localparam int          MAX_LEN      = 63;
    localparam logic [15:0] DLFLOAT_NAN  = 16'hFFFF;
    localparam int          DLFLOAT_BIAS = 31;
    localparam logic [1:0]  OP_START     = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_HI,
        ST_A_LO,
        ST_B_HI,
        ST_B_LO
    } seq_state_e;

    typedef struct packed {
        logic [1:0] opcode;
        logic [5:0] len;
    } header_t;

    function automatic logic is_nan(input logic [15:0] v);
        return v == DLFLOAT_NAN;
    endfunction

endpackage

// File: rtl/dlfloat_operand_sequencer_if.sv
// Byte stream in, operand pair out, plus MAC control pulses. The master
// modport is the sequencer; the slave modport is its environment.
interface dlfloat_operand_sequencer_if;

    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_valid;
    logic        op_ready;
    logic        op_last;
    logic        acc_clr;
    logic        done;
    logic        nan_seen;

    modport master (
        input  in_byte, in_valid, op_ready,
        output in_ready, op_a, op_b, op_valid, op_last, acc_clr, done, nan_seen
    );

    modport slave (
        output in_byte, in_valid, op_ready,
        input  in_ready, op_a, op_b, op_valid, op_last, acc_clr, done, nan_seen
    );

endinterface

// File: rtl/dlfloat_operand_sequencer.sv
// Assembles framed byte stream {header, N x {a_hi,a_lo,b_hi,b_lo}} into
// DLFloat16 operand pairs for the MAC, with accumulator-clear and done pulses.
module dlfloat_operand_sequencer
    import dlfloat_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    dlfloat_operand_sequencer_if.master       bus
);

    seq_state_e  state_q;
    logic [5:0]  rem_q;
    logic [7:0]  a_hi_q;
    logic [7:0]  a_lo_q;
    logic [7:0]  b_hi_q;
    logic [15:0] op_a_q;
    logic [15:0] op_b_q;
    logic        op_valid_q;
    logic        op_last_q;
    logic        acc_clr_q;
    logic        done_q;
    logic        nan_seen_q;

    header_t     hdr;
    logic        byte_acc;
    logic        pair_pop;
    logic [15:0] pair_a_d;
    logic [15:0] pair_b_d;
    logic        last_pair_d;

    // A held pair stalls every byte, headers included.
    assign bus.in_ready = !op_valid_q || bus.op_ready;
    assign byte_acc     = bus.in_valid && bus.in_ready;
    assign pair_pop     = op_valid_q && bus.op_ready;

    assign hdr          = bus.in_byte;
    assign pair_a_d     = {a_hi_q, a_lo_q};
    assign pair_b_d     = {b_hi_q, bus.in_byte};
    assign last_pair_d  = (rem_q == 6'd1);

    // NOTE: every register here, byte staging included, is cleared by the async
    // reset so a frame cut short leaves no stale partial operand behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            a_hi_q     <= '0;
            a_lo_q     <= '0;
            b_hi_q     <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            op_last_q  <= 1'b0;
            acc_clr_q  <= 1'b0;
            done_q     <= 1'b0;
            nan_seen_q <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; a later assignment to the same
            // register in this block overrides an earlier one, so a pair
            // loading in the same cycle as a pop keeps op_valid_q set.
            acc_clr_q <= 1'b0;
            done_q    <= pair_pop && op_last_q;
            if (pair_pop) begin
                op_valid_q <= 1'b0;
            end

            if (byte_acc) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (hdr.opcode == OP_START && hdr.len != '0) begin
                            rem_q      <= hdr.len;
                            acc_clr_q  <= 1'b1;
                            nan_seen_q <= 1'b0;
                            state_q    <= ST_A_HI;
                        end
                    end
                    ST_A_HI: begin
                        a_hi_q  <= bus.in_byte;
                        state_q <= ST_A_LO;
                    end
                    ST_A_LO: begin
                        a_lo_q  <= bus.in_byte;
                        state_q <= ST_B_HI;
                    end
                    ST_B_HI: begin
                        b_hi_q  <= bus.in_byte;
                        state_q <= ST_B_LO;
                    end
                    ST_B_LO: begin
                        op_a_q     <= pair_a_d;
                        op_b_q     <= pair_b_d;
                        op_valid_q <= 1'b1;
                        op_last_q  <= last_pair_d;
                        rem_q      <= rem_q - 6'd1;
                        if (is_nan(pair_a_d) || is_nan(pair_b_d)) begin
                            nan_seen_q <= 1'b1;
                        end
                        state_q    <= last_pair_d ? ST_IDLE : ST_A_HI;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
    assign bus.op_valid = op_valid_q;
    assign bus.op_last  = op_last_q;
    assign bus.acc_clr  = acc_clr_q;
    assign bus.done     = done_q;
    assign bus.nan_seen = nan_seen_q;

endmodule

// File: tb/tb_dlfloat_operand_sequencer.sv
// Self-checking bench for dlfloat_operand_sequencer: table of frames plus
// hand-written stall, back-to-back and reset sequences, scoreboarded outputs.
module tb_dlfloat_operand_sequencer;
    import dlfloat_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dlfloat_operand_sequencer_if bus ();

    dlfloat_operand_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        last;
    } exp_pair_t;

    typedef struct {
        logic [7:0]  hdr;
        int          n;
        logic [15:0] a [3];
        logic [15:0] b [3];
        int          exp_acc;
        logic        exp_nan;
    } vec_t;

    int        n_vec = 0;
    int        n_bad = 0;
    int        cyc   = 0;
    exp_pair_t sb_q [$];
    exp_pair_t e;
    int        hand_cyc [$];
    int        clr_cyc [$];
    int        done_cyc [$];
    logic      exp_done_next = 1'b0;
    vec_t      tbl [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: samples mid-low-phase, pops the scoreboard on each handoff.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            exp_done_next = 1'b0;
        end else begin
            if (bus.acc_clr) clr_cyc.push_back(cyc);
            if (exp_done_next || bus.done) check("done_pulse", bus.done, exp_done_next);
            if (bus.done) done_cyc.push_back(cyc);
            exp_done_next = 1'b0;
            if (bus.op_valid && bus.op_ready) begin
                hand_cyc.push_back(cyc);
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL sb_underflow: got pair %h/%h with nothing expected", bus.op_a, bus.op_b);
                end else begin
                    e = sb_q.pop_front();
                    check("op_a", bus.op_a, e.a);
                    check("op_b", bus.op_b, e.b);
                    check("op_last", bus.op_last, e.last);
                    exp_done_next = e.last;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) begin
            n_vec++;
            n_bad++;
            $display("FAIL in_ready_timeout: byte %h never accepted", b);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
        sb_q.push_back('{a: a, b: b, last: last});
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(b[15:8]);
        send_byte(b[7:0]);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        hand_cyc.delete();
        clr_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op_valid"}, bus.op_valid, 1'b0);
        check({tag, "_op_a"},     bus.op_a,     16'h0000);
        check({tag, "_op_b"},     bus.op_b,     16'h0000);
        check({tag, "_op_last"},  bus.op_last,  1'b0);
        check({tag, "_acc_clr"},  bus.acc_clr,  1'b0);
        check({tag, "_done"},     bus.done,     1'b0);
        check({tag, "_nan_seen"}, bus.nan_seen, 1'b0);
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{hdr: 8'h41, n: 1, a: '{16'h3E00, 16'h0, 16'h0}, b: '{16'h4000, 16'h0, 16'h0}, exp_acc: 1, exp_nan: 1'b0};
        tbl[1] = '{hdr: 8'h43, n: 3, a: '{16'h1234, 16'h0000, 16'h7FFF}, b: '{16'h5678, 16'h0000, 16'h8001}, exp_acc: 1, exp_nan: 1'b0};
        tbl[2] = '{hdr: 8'h00, n: 0, a: '{16'h0, 16'h0, 16'h0}, b: '{16'h0, 16'h0, 16'h0}, exp_acc: 0, exp_nan: 1'b0};
        tbl[3] = '{hdr: 8'h40, n: 0, a: '{16'h0, 16'h0, 16'h0}, b: '{16'h0, 16'h0, 16'h0}, exp_acc: 0, exp_nan: 1'b0};
        tbl[4] = '{hdr: 8'h42, n: 2, a: '{16'hFFFF, 16'h0001, 16'h0}, b: '{16'h3C00, 16'hFE00, 16'h0}, exp_acc: 1, exp_nan: 1'b1};
        tbl[5] = '{hdr: 8'hC1, n: 0, a: '{16'h0, 16'h0, 16'h0}, b: '{16'h0, 16'h0, 16'h0}, exp_acc: 0, exp_nan: 1'b1};
        tbl[6] = '{hdr: 8'h41, n: 1, a: '{16'h4000, 16'h0, 16'h0}, b: '{16'hFFFF, 16'h0, 16'h0}, exp_acc: 1, exp_nan: 1'b1};
        tbl[7] = '{hdr: 8'h41, n: 1, a: '{16'h1111, 16'h0, 16'h0}, b: '{16'h2222, 16'h0, 16'h0}, exp_acc: 1, exp_nan: 1'b0};

        bus.in_byte  = 8'h00;
        bus.in_valid = 1'b0;
        bus.op_ready = 1'b1;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven frames at full rate.
        for (int v = 0; v < 8; v++) begin
            clear_logs();
            send_byte(tbl[v].hdr);
            for (int i = 0; i < tbl[v].n; i++) begin
                send_pair(tbl[v].a[i], tbl[v].b[i], i == tbl[v].n - 1);
            end
            idle(6);
            check("acc_clr_count", clr_cyc.size(), tbl[v].exp_acc);
            check("done_count", done_cyc.size(), (tbl[v].n > 0) ? 1 : 0);
            check("nan_seen", bus.nan_seen, tbl[v].exp_nan);
            check("pairs_out", hand_cyc.size(), tbl[v].n);
            check("sb_empty", sb_q.size(), 0);
            check("op_valid_idle", bus.op_valid, 1'b0);
            if (tbl[v].n > 0 && hand_cyc.size() > 0 && clr_cyc.size() > 0) begin
                check("clr_lead_ge4", (hand_cyc[0] - clr_cyc[0]) >= 4, 1'b1);
            end
            for (int i = 1; i < hand_cyc.size(); i++) begin
                check("pair_spacing", hand_cyc[i] - hand_cyc[i-1], 4);
            end
        end

        // Back-pressure: first pair held 5 cycles, second pair stalled behind it.
        clear_logs();
        fork
            begin
                send_byte(8'h42);
                send_pair(16'hAAAA, 16'h5555, 1'b0);
                send_pair(16'hC1C0, 16'h0201, 1'b1);
            end
            begin
                int guard = 0;
                bus.op_ready = 1'b0;
                @(negedge clk);
                #2;
                while (!bus.op_valid && guard < 50) begin
                    @(negedge clk);
                    #2;
                    guard++;
                end
                check("stall_pair_seen", bus.op_valid, 1'b1);
                for (int k = 0; k < 5; k++) begin
                    check("stall_in_ready", bus.in_ready, 1'b0);
                    check("stall_op_a", bus.op_a, 16'hAAAA);
                    check("stall_op_b", bus.op_b, 16'h5555);
                    @(negedge clk);
                    #2;
                end
                @(negedge clk);
                bus.op_ready = 1'b1;
            end
        join
        idle(6);
        check("stall_pairs_out", hand_cyc.size(), 2);
        check("stall_done_count", done_cyc.size(), 1);
        check("stall_sb_empty", sb_q.size(), 0);

        // Back-to-back frames: done of frame 1 never after acc_clr of frame 2.
        clear_logs();
        send_byte(8'h41);
        send_pair(16'h0102, 16'h0304, 1'b1);
        send_byte(8'h41);
        send_pair(16'h0506, 16'h0708, 1'b1);
        idle(6);
        check("b2b_acc_clr_count", clr_cyc.size(), 2);
        check("b2b_done_count", done_cyc.size(), 2);
        if (clr_cyc.size() == 2 && done_cyc.size() == 2) begin
            check("b2b_order", done_cyc[0] <= clr_cyc[1], 1'b1);
            check("b2b_order_first", clr_cyc[0] < done_cyc[0], 1'b1);
        end

        // Reset while a NaN pair is held: op_valid must drop without a clock edge.
        clear_logs();
        bus.op_ready = 1'b0;
        send_byte(8'h41);
        send_pair(16'hFFFF, 16'h0001, 1'b1);
        #3;
        check("held_valid", bus.op_valid, 1'b1);
        check("held_nan", bus.nan_seen, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_op_valid", bus.op_valid, 1'b0);
        check("async_nan_seen", bus.nan_seen, 1'b0);
        sb_q.delete();
        bus.op_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset after a_lo of pair 1, then a clean frame.
        clear_logs();
        send_byte(8'h41);
        send_byte(8'h12);
        send_byte(8'h34);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midframe_no_done", done_cyc.size(), 0);
        clear_logs();
        send_byte(8'h41);
        send_pair(16'h3E00, 16'h4000, 1'b1);
        idle(6);
        check("post_reset_pairs", hand_cyc.size(), 1);
        check("post_reset_done", done_cyc.size(), 1);
        check("post_reset_acc_clr", clr_cyc.size(), 1);
        check("post_reset_sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
